fir_tap_mult: RTL and testbench

Front-end stage of the FIR filter. It holds the sample delay line and a writable coefficient bank, and forms one registered signed product per tap. The packed product vector drives the `addertree` `inputd` port directly. A valid pipeline delays the product strobe by the adder tree's register depth, so downstream logic can qualify `sum` without any knowledge of the tree's latency.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_coef_bank.sv | 39 +++
 rtl/fir_tap_mult.sv | 104 ++++++++++
 tb/tb_fir_tap_mult.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR sizing constants and helpers for the tap/multiply front end and the adder tree.
package fir_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned COEF_WIDTH = 8;
  localparam int unsigned NUM_TAPS   = 53;
  localparam int unsigned PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  // Register levels in a binary adder tree reducing n inputs.
  function automatic int unsigned tree_stages(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Writable coefficient register bank with a one-hot write decode.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned COEF_WIDTH = fir_pkg::COEF_WIDTH,
  parameter int unsigned NUM_TAPS   = fir_pkg::NUM_TAPS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_TAPS)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 coef_we,
  input  logic [ADDR_WIDTH-1:0]                coef_addr,
  input  logic [COEF_WIDTH-1:0]                coef_data,
  output logic [NUM_TAPS-1:0][COEF_WIDTH-1:0]  coef
);

  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef_q, coef_d;

  // Addresses at or beyond NUM_TAPS match no entry, so such writes are dropped.
  always_comb begin
    coef_d = coef_q;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      if (coef_we && (coef_addr == ADDR_WIDTH'(i))) begin
        coef_d[i] = coef_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      coef_q <= '0;
    end else begin
      coef_q <= coef_d;
    end
  end

  assign coef = coef_q;

endmodule

// File: rtl/fir_tap_mult.sv
// FIR front end: sample delay line, per-tap registered products and a valid pipe
// matched to the downstream adder tree latency.
module fir_tap_mult
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = fir_pkg::DATA_WIDTH,
  parameter int unsigned COEF_WIDTH  = fir_pkg::COEF_WIDTH,
  parameter int unsigned NUM_TAPS    = fir_pkg::NUM_TAPS,
  parameter int unsigned PROD_WIDTH  = DATA_WIDTH + COEF_WIDTH,
  parameter int unsigned TREE_STAGES = tree_stages(NUM_TAPS)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 in_valid,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 flush,
  input  logic                                 coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]          coef_addr,
  input  logic [COEF_WIDTH-1:0]                coef_data,
  output logic [NUM_TAPS-1:0][PROD_WIDTH-1:0]  products,
  output logic                                 prod_valid,
  output logic                                 sum_valid,
  output logic                                 primed
);

  localparam int unsigned AddrWidth = $clog2(NUM_TAPS);
  localparam int unsigned CntWidth  = $clog2(NUM_TAPS + 1);

  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_q, tap_d;
  logic [NUM_TAPS-1:0][PROD_WIDTH-1:0] products_q, products_d;
  logic                                s1_valid_q, s1_valid_d;
  logic                                prod_valid_q, prod_valid_d;
  logic [TREE_STAGES-1:0]              sv_q, sv_d;
  logic [CntWidth-1:0]                 cnt_q, cnt_d;

  fir_coef_bank #(
    .COEF_WIDTH (COEF_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .ADDR_WIDTH (AddrWidth)
  ) u_coef_bank (
    .clk       (clk),
    .resetn    (resetn),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef      (coef)
  );

  // Flush wins over a coincident sample; products are left untouched by it.
  always_comb begin
    tap_d        = tap_q;
    products_d   = products_q;
    s1_valid_d   = in_valid && !flush;
    prod_valid_d = s1_valid_q && !flush;
    cnt_d        = cnt_q;
    sv_d[0]      = prod_valid_q;
    for (int unsigned i = 1; i < TREE_STAGES; i++) begin
      sv_d[i] = sv_q[i-1];
    end

    if (flush) begin
      tap_d = '0;
      cnt_d = '0;
      sv_d  = '0;
    end else begin
      if (in_valid) begin
        tap_d = {tap_q[NUM_TAPS-2:0], in_data};
        if (cnt_q != CntWidth'(NUM_TAPS)) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
          products_d[i] = PROD_WIDTH'($signed(tap_q[i])) * PROD_WIDTH'($signed(coef[i]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tap_q        <= '0;
      products_q   <= '0;
      s1_valid_q   <= 1'b0;
      prod_valid_q <= 1'b0;
      sv_q         <= '0;
      cnt_q        <= '0;
    end else begin
      tap_q        <= tap_d;
      products_q   <= products_d;
      s1_valid_q   <= s1_valid_d;
      prod_valid_q <= prod_valid_d;
      sv_q         <= sv_d;
      cnt_q        <= cnt_d;
    end
  end

  assign products   = products_q;
  assign prod_valid = prod_valid_q;
  assign sum_valid  = sv_q[TREE_STAGES-1];
  assign primed     = (cnt_q == CntWidth'(NUM_TAPS));

endmodule

// File: tb/tb_fir_tap_mult.sv
// Directed bench for fir_tap_mult: reference model of taps/coefficients feeds a
// scoreboard of expected product vectors, strobe cycles and adder-tree sums.
module tb_fir_tap_mult;

  localparam int N  = 53;
  localparam int TS = 6;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  flush;
  logic                  coef_we;
  logic [5:0]            coef_addr;
  logic [7:0]            coef_data;
  logic [N-1:0][15:0]    products;
  logic                  prod_valid;
  logic                  sum_valid;
  logic                  primed;

  fir_tap_mult dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .products   (products),
    .prod_valid (prod_valid),
    .sum_valid  (sum_valid),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic [N-1:0][15:0] prods;
  } pexp_t;

  typedef struct {
    int cyc;
    int sum;
  } sexp_t;

  pexp_t prod_q[$];
  sexp_t sum_q[$];
  int    dut_sum_q[$];

  logic signed [7:0] mtap  [N];
  logic signed [7:0] mcoef [N];
  int mcnt;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int last_sum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear(input bit coefs_too);
    for (int i = 0; i < N; i++) begin
      mtap[i] = '0;
      if (coefs_too) mcoef[i] = '0;
    end
    mcnt = 0;
    prod_q.delete();
    sum_q.delete();
    dut_sum_q.delete();
  endtask

  // Drive one cycle of inputs, then advance the model by the edge that samples them.
  task automatic tick(input bit v, input logic signed [7:0] d, input bit we,
                      input logic [5:0] a, input logic signed [7:0] cd, input bit fl);
    pexp_t pe;
    sexp_t se;
    int    p;
    in_valid  = v;
    in_data   = d;
    coef_we   = we;
    coef_addr = a;
    coef_data = cd;
    flush     = fl;
    @(posedge clk);
    #1;
    if (fl) model_clear(1'b0);
    if (we && a < 6'(N)) mcoef[a] = cd;
    if (v && !fl) begin
      for (int i = N - 1; i > 0; i--) mtap[i] = mtap[i-1];
      mtap[0] = d;
      if (mcnt < N) mcnt++;
      se.sum = 0;
      for (int i = 0; i < N; i++) begin
        p = mtap[i] * mcoef[i];
        pe.prods[i] = p[15:0];
        se.sum += p;
      end
      pe.cyc = cyc + 1;
      se.cyc = cyc + 1 + TS;
      prod_q.push_back(pe);
      sum_q.push_back(se);
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'sd0, 1'b0, 6'd0, 8'sd0, 1'b0);
  endtask

  // Scoreboard: every strobe must match an expected entry at exactly its cycle.
  always @(negedge clk) begin
    bit exp_pv;
    bit exp_sv;
    int s;
    if (resetn === 1'b1) begin
      exp_pv = (prod_q.size() > 0) && (prod_q[0].cyc == cyc);
      if (prod_valid || exp_pv) begin
        tests++;
        assert (prod_valid === exp_pv) else begin
          fails++;
          $error("FAIL prod_valid@%0d: got %0b expected %0b", cyc, prod_valid, exp_pv);
        end
      end
      if (prod_valid && exp_pv) begin
        tests++;
        assert (products === prod_q[0].prods) else begin
          fails++;
          $error("FAIL products@%0d: got %h expected %h", cyc, products, prod_q[0].prods);
        end
      end
      if (prod_valid) begin
        s = 0;
        for (int i = 0; i < N; i++) s += $signed(products[i]);
        dut_sum_q.push_back(s);
      end
      if (exp_pv) void'(prod_q.pop_front());

      exp_sv = (sum_q.size() > 0) && (sum_q[0].cyc == cyc);
      if (sum_valid || exp_sv) begin
        tests++;
        assert (sum_valid === exp_sv) else begin
          fails++;
          $error("FAIL sum_valid@%0d: got %0b expected %0b", cyc, sum_valid, exp_sv);
        end
      end
      if (sum_valid && exp_sv) begin
        s = (dut_sum_q.size() > 0) ? dut_sum_q[0] : 32'h7fff_ffff;
        last_sum = s;
        tests++;
        assert (s === sum_q[0].sum) else begin
          fails++;
          $error("FAIL sum@%0d: got %0d expected %0d", cyc, s, sum_q[0].sum);
        end
      end
      if (sum_valid && dut_sum_q.size() > 0) void'(dut_sum_q.pop_front());
      if (exp_sv) void'(sum_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_clear(1'b1);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset then idle
    idle(2);
    chk("rst_products_zero", int'(products === '0), 1);
    chk("rst_prod_valid", int'(prod_valid), 0);
    chk("rst_sum_valid", int'(sum_valid), 0);
    chk("rst_primed", int'(primed), 0);

    // All-ones coefficients and samples
    for (int i = 0; i < N; i++) tick(1'b0, 8'sd0, 1'b1, 6'(i), 8'sd1, 1'b0);
    for (int i = 0; i < N; i++) begin
      tick(1'b1, 8'sd1, 1'b0, 6'd0, 8'sd0, 1'b0);
      if (i == N - 2) chk("primed_at_52", int'(primed), 0);
      if (i == N - 1) chk("primed_at_53", int'(primed), 1);
    end
    idle(TS + 3);
    chk("sum_ones_53", last_sum, 53);

    // Mid-stream reset discards in-flight strobes
    tick(1'b1, 8'sd1, 1'b0, 6'd0, 8'sd0, 1'b0);
    tick(1'b1, 8'sd1, 1'b0, 6'd0, 8'sd0, 1'b0);
    chk("pre_rst_prod_valid", int'(prod_valid), 1);
    resetn = 1'b0;
    #1;
    chk("midrst_prod_valid", int'(prod_valid), 0);
    chk("midrst_sum_valid", int'(sum_valid), 0);
    chk("midrst_primed", int'(primed), 0);
    chk("midrst_products", int'(products === '0), 1);
    model_clear(1'b1);
    @(negedge clk);
    #2 resetn = 1'b1;
    idle(TS + 3);

    // Impulse walk with coef[i] = i - 26; out-of-range write must be ignored
    for (int i = 0; i < N; i++) tick(1'b0, 8'sd0, 1'b1, 6'(i), 8'(i - 26), 1'b0);
    tick(1'b0, 8'sd0, 1'b1, 6'd60, 8'sd99, 1'b0);
    tick(1'b1, 8'sd1, 1'b0, 6'd0, 8'sd0, 1'b0);
    for (int i = 0; i < N; i++) tick(1'b1, 8'sd0, 1'b0, 6'd0, 8'sd0, 1'b0);
    idle(TS + 3);

    // Extremes, including a coefficient write coincident with the sample
    tick(1'b0, 8'sd0, 1'b1, 6'd0, -8'sd128, 1'b0);
    tick(1'b1, -8'sd128, 1'b0, 6'd0, 8'sd0, 1'b0);
    idle(2);
    chk("ext_neg_neg", int'($signed(products[0])), 16384);
    tick(1'b1, -8'sd128, 1'b1, 6'd0, 8'sd127, 1'b0);
    idle(2);
    chk("ext_pos_neg_same_edge", int'($signed(products[0])), -16256);
    idle(TS + 2);

    // Flush together with in_valid
    for (int i = 0; i < N; i++) tick(1'b0, 8'sd0, 1'b1, 6'(i), 8'sd1, 1'b0);
    for (int i = 0; i < N + 3; i++) tick(1'b1, 8'sd1, 1'b0, 6'd0, 8'sd0, 1'b0);
    chk("pre_flush_primed", int'(primed), 1);
    tick(1'b1, 8'sd5, 1'b0, 6'd0, 8'sd0, 1'b1);
    chk("flush_primed", int'(primed), 0);
    chk("flush_prod_valid", int'(prod_valid), 0);
    idle(TS + 3);
    for (int i = 0; i < N; i++) begin
      tick(1'b1, 8'sd1, 1'b0, 6'd0, 8'sd0, 1'b0);
      if (i == N - 2) chk("post_flush_primed_52", int'(primed), 0);
    end
    chk("post_flush_primed_53", int'(primed), 1);
    idle(TS + 3);
    chk("post_flush_sum_53", last_sum, 53);
    chk("scoreboard_drained", prod_q.size() + sum_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
